// File: rtl/instr_encoder_if.sv
// Descriptor request and instruction-memory write bus for instr_encoder.
// The master drives descriptors and im_stall; the slave (encoder) drives the rest.
interface instr_encoder_if #(
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_op;
  logic [4:0]        req_rs;
  logic [4:0]        req_rt;
  logic [4:0]        req_rd;
  logic [25:0]       req_imm;
  logic              req_last;
  logic              im_stall;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output req_valid, req_op, req_rs, req_rt, req_rd, req_imm, req_last, im_stall,
    input  req_ready, im_we, im_addr, im_wdata, busy, done, err
  );

  modport slave (
    input  req_valid, req_op, req_rs, req_rt, req_rd, req_imm, req_last, im_stall,
    output req_ready, im_we, im_addr, im_wdata, busy, done, err
  );
endinterface

// File: rtl/instr_encoder.sv
// MIPS instruction encoder/loader: descriptors -> 32-bit words -> FIFO -> sequential IM writes.
// Optional macro INSTR_ENC_ILLEGAL_TRAP_EN: drop illegal ops and flag them in err.
module instr_encoder #(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  instr_encoder_if.slave        bus
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  localparam logic [3:0] OP_ADDU = 4'd0,  OP_SUBU = 4'd1, OP_ADD  = 4'd2,  OP_ORI  = 4'd3,
                         OP_LUI  = 4'd4,  OP_LW   = 4'd5, OP_SW   = 4'd6,  OP_ADDI = 4'd7,
                         OP_BEQ  = 4'd8,  OP_BGTZ = 4'd9, OP_J    = 4'd10, OP_JAL  = 4'd11,
                         OP_JR   = 4'd12;

  typedef struct packed {
    logic [3:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [25:0] imm;
    logic        last;
  } req_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state;
  req_t              req;
  logic [31:0]       encWord;
  logic [31:0]       mem [DEPTH];
  logic [PW:0]       wrPtr, rdPtr;
  logic              fifoEmpty, fifoFull;
  logic              accept, push, pop;
  logic [ADDR_W-1:0] addrCnt;
  logic              imWe;
  logic [ADDR_W-1:0] imAddr;
  logic [31:0]       imWdata;
  logic              busyR, doneR, errR;

  assign req = '{op: bus.req_op, rs: bus.req_rs, rt: bus.req_rt, rd: bus.req_rd,
                 imm: bus.req_imm, last: bus.req_last};

  always_comb begin
    encWord = '0;
    case (req.op)
      OP_ADDU: encWord = {6'h00, req.rs, req.rt, req.rd, 5'd0, 6'h21};
      OP_SUBU: encWord = {6'h00, req.rs, req.rt, req.rd, 5'd0, 6'h23};
      OP_ADD:  encWord = {6'h00, req.rs, req.rt, req.rd, 5'd0, 6'h20};
      OP_JR:   encWord = {6'h00, req.rs, 15'd0, 6'h08};
      OP_ORI:  encWord = {6'h0D, req.rs, req.rt, req.imm[15:0]};
      OP_LUI:  encWord = {6'h0F, 5'd0,   req.rt, req.imm[15:0]};
      OP_LW:   encWord = {6'h23, req.rs, req.rt, req.imm[15:0]};
      OP_SW:   encWord = {6'h2B, req.rs, req.rt, req.imm[15:0]};
      OP_ADDI: encWord = {6'h08, req.rs, req.rt, req.imm[15:0]};
      OP_BEQ:  encWord = {6'h04, req.rs, req.rt, req.imm[15:0]};
      OP_BGTZ: encWord = {6'h07, req.rs, 5'd0,   req.imm[15:0]};
      OP_J:    encWord = {6'h02, req.imm};
      OP_JAL:  encWord = {6'h03, req.imm};
      default: encWord = '0;
    endcase
  end

  assign fifoEmpty = (wrPtr == rdPtr);
  assign fifoFull  = (wrPtr[PW] != rdPtr[PW]) && (wrPtr[PW-1:0] == rdPtr[PW-1:0]);

  assign bus.req_ready = (state == RUN) && !fifoFull;
  assign accept        = bus.req_valid && bus.req_ready;
`ifdef INSTR_ENC_ILLEGAL_TRAP_EN
  logic illegalOp;
  assign illegalOp = (req.op > OP_JR);
  assign push      = accept && !illegalOp;
`else
  assign push      = accept;
`endif
  assign pop = !fifoEmpty && !bus.im_stall;

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr[PW-1:0]] <= encWord;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      wrPtr   <= '0;
      rdPtr   <= '0;
      addrCnt <= BASE;
      imWe    <= 1'b0;
      imAddr  <= BASE;
      imWdata <= '0;
      busyR   <= 1'b0;
      doneR   <= 1'b0;
      errR    <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;

      imWe <= pop;
      if (pop) begin
        imAddr  <= addrCnt;
        imWdata <= mem[rdPtr[PW-1:0]];
        addrCnt <= addrCnt + 1'b1;
        if (&addrCnt) errR <= 1'b1;
      end
`ifdef INSTR_ENC_ILLEGAL_TRAP_EN
      if (accept && illegalOp) errR <= 1'b1;
`endif

      case (state)
        IDLE, DONE: if (start) begin
          state   <= RUN;
          addrCnt <= BASE;
          errR    <= 1'b0;
          busyR   <= 1'b1;
          doneR   <= 1'b0;
        end
        RUN: if (accept && req.last) state <= DRAIN;
        // FIFO empty in DRAIN means the final word is already on the write port
        DRAIN: if (fifoEmpty) begin
          state <= DONE;
          busyR <= 1'b0;
          doneR <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.im_we    = imWe;
  assign bus.im_addr  = imAddr;
  assign bus.im_wdata = imWdata;
  assign bus.busy     = busyR;
  assign bus.done     = doneR;
  assign bus.err      = errR;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a 10-bit-address instance and a 2-bit-address instance
// share the same stimulus; each has its own scoreboard of expected IM writes.
module tb_instr_encoder;
  logic clk = 1'b0;
  logic reset, start;
  always #5 clk = ~clk;

  instr_encoder_if #(.ADDR_W(10)) busA ();
  instr_encoder_if #(.ADDR_W(2))  busB ();

  assign busB.req_valid = busA.req_valid;
  assign busB.req_op    = busA.req_op;
  assign busB.req_rs    = busA.req_rs;
  assign busB.req_rt    = busA.req_rt;
  assign busB.req_rd    = busA.req_rd;
  assign busB.req_imm   = busA.req_imm;
  assign busB.req_last  = busA.req_last;
  assign busB.im_stall  = busA.im_stall;

  instr_encoder #(.DEPTH(4), .ADDR_W(10), .BASE_ADDR(0)) dutA (.clk(clk), .reset(reset), .start(start), .bus(busA));
  instr_encoder #(.DEPTH(4), .ADDR_W(2),  .BASE_ADDR(0)) dutB (.clk(clk), .reset(reset), .start(start), .bus(busB));

  typedef struct { logic [9:0] addr; logic [31:0] word; } exp_t;
  exp_t qA[$], qB[$];
  exp_t eA, eB;
  int total = 0, bad = 0;
  int nA = 0, nB = 0;
  int wrCntA = 0, cyc = 0;
  int wrCyc[$];

`ifdef INSTR_ENC_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (busA.im_we) begin
      wrCntA++;
      wrCyc.push_back(cyc);
      total++;
      assert (qA.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_we_A observed=%0h expected=none", busA.im_addr);
      end
      if (qA.size() != 0) begin
        eA = qA.pop_front();
        total++;
        assert ({busA.im_addr, busA.im_wdata} === {eA.addr, eA.word}) else begin
          bad++;
          $error("FAIL write_A observed=%0h/%08h expected=%0h/%08h", busA.im_addr, busA.im_wdata, eA.addr, eA.word);
        end
      end
    end
    if (busB.im_we) begin
      total++;
      assert (qB.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_we_B observed=%0h expected=none", busB.im_addr);
      end
      if (qB.size() != 0) begin
        eB = qB.pop_front();
        total++;
        assert ({8'd0, busB.im_addr, busB.im_wdata} === {eB.addr, eB.word}) else begin
          bad++;
          $error("FAIL write_B observed=%0h/%08h expected=%0h/%08h", busB.im_addr, busB.im_wdata, eB.addr, eB.word);
        end
      end
    end
  end

  function automatic logic [31:0] model(input logic [3:0] op, input logic [4:0] rs, rt, rd,
                                        input logic [25:0] imm);
    logic [15:0] i16;
    i16 = imm[15:0];
    case (op)
      4'd0:  return {6'h00, rs, rt, rd, 5'd0, 6'h21};
      4'd1:  return {6'h00, rs, rt, rd, 5'd0, 6'h23};
      4'd2:  return {6'h00, rs, rt, rd, 5'd0, 6'h20};
      4'd3:  return {6'h0D, rs, rt, i16};
      4'd4:  return {6'h0F, 5'd0, rt, i16};
      4'd5:  return {6'h23, rs, rt, i16};
      4'd6:  return {6'h2B, rs, rt, i16};
      4'd7:  return {6'h08, rs, rt, i16};
      4'd8:  return {6'h04, rs, rt, i16};
      4'd9:  return {6'h07, rs, 5'd0, i16};
      4'd10: return {6'h02, imm};
      4'd11: return {6'h03, imm};
      4'd12: return {6'h00, rs, 21'h000008};
      default: return 32'h0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic expectWrite(input logic [31:0] w);
    qA.push_back('{addr: 10'(nA % 1024), word: w});
    qB.push_back('{addr: 10'(nB % 4), word: w});
    nA++; nB++;
  endtask

  task automatic drive(input logic [3:0] op, input logic [4:0] rs, rt, rd,
                       input logic [25:0] imm, input logic last);
    busA.req_valid = 1'b1;
    busA.req_op = op; busA.req_rs = rs; busA.req_rt = rt; busA.req_rd = rd;
    busA.req_imm = imm; busA.req_last = last;
  endtask

  // Hold the descriptor until accepted; record the expected word at the accepting edge.
  task automatic send(input logic [3:0] op, input logic [4:0] rs, rt, rd,
                      input logic [25:0] imm, input logic last,
                      input logic [31:0] w, input bit pushes);
    bit acc;
    acc = 1'b0;
    drive(op, rs, rt, rd, imm, last);
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = busA.req_ready;
      tick();
    end
    if (!acc) chk("accept_timeout", 0, 1);
    else if (pushes) expectWrite(w);
  endtask

  task automatic idleReq();
    busA.req_valid = 1'b0;
  endtask

  task automatic doStart();
    start = 1'b1; tick(); start = 1'b0;
    nA = 0; nB = 0;
  endtask

  task automatic waitDone();
    for (int i = 0; i < 100 && !busA.done; i++) tick();
    chk("done", busA.done, 1);
    chk("busy_after_done", busA.busy, 0);
    chk("qA_drained", qA.size(), 0);
    chk("qB_drained", qB.size(), 0);
  endtask

  task automatic chkResetVals(input string tag);
    chk({tag, "_ready"}, busA.req_ready, 0);
    chk({tag, "_we"},    busA.im_we, 0);
    chk({tag, "_addr"},  busA.im_addr, 0);
    chk({tag, "_wdata"}, busA.im_wdata, 0);
    chk({tag, "_busy"},  busA.busy, 0);
    chk({tag, "_done"},  busA.done, 0);
    chk({tag, "_err"},   busA.err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int w0, s0;
    reset = 1'b1; start = 1'b0;
    busA.req_valid = 0; busA.req_op = 0; busA.req_rs = 0; busA.req_rt = 0; busA.req_rd = 0;
    busA.req_imm = 0; busA.req_last = 0; busA.im_stall = 0;
    repeat (3) tick();
    chkResetVals("reset");
    reset = 1'b0;
    tick();

    // single ADDU
    doStart();
    chk("run_busy", busA.busy, 1);
    chk("run_done", busA.done, 0);
    chk("run_ready", busA.req_ready, 1);
    w0 = wrCntA;
    send(4'd0, 5'd1, 5'd2, 5'd3, 26'd0, 1'b1, 32'h00221821, 1'b1);
    idleReq();
    waitDone();
    chk("addu_writes", wrCntA - w0, 1);
    tick();
    chk("hold_we", busA.im_we, 0);
    chk("hold_addr", busA.im_addr, 0);
    chk("hold_wdata", busA.im_wdata, 32'h00221821);

    // ORI / LUI / JAL
    doStart();
    send(4'd3, 5'd0, 5'd8, 5'd0, 26'h1234, 1'b0, 32'h34081234, 1'b1);
    send(4'd4, 5'd5, 5'd9, 5'd0, 26'hFFFF, 1'b0, 32'h3C09FFFF, 1'b1);
    send(4'd11, 5'd0, 5'd0, 5'd0, 26'hC00, 1'b1, 32'h0C000C00, 1'b1);
    idleReq();
    waitDone();

    // FIFO fill under stall, then release
    doStart();
    busA.im_stall = 1'b1;
    w0 = wrCntA;
    send(4'd0, 5'd4, 5'd5, 5'd6, 26'd0, 1'b0, model(4'd0, 5'd4, 5'd5, 5'd6, 26'd0), 1'b1);
    send(4'd1, 5'd7, 5'd8, 5'd9, 26'd0, 1'b0, model(4'd1, 5'd7, 5'd8, 5'd9, 26'd0), 1'b1);
    send(4'd5, 5'd2, 5'd3, 5'd0, 26'h0010, 1'b0, model(4'd5, 5'd2, 5'd3, 5'd0, 26'h0010), 1'b1);
    send(4'd6, 5'd29, 5'd31, 5'd0, 26'h3FFFFFC, 1'b0, model(4'd6, 5'd29, 5'd31, 5'd0, 26'h3FFFFFC), 1'b1);
    drive(4'd2, 5'd10, 5'd11, 5'd12, 26'd0, 1'b0);
    repeat (3) tick();
    chk("full_ready", busA.req_ready, 0);
    chk("stall_no_we", wrCntA - w0, 0);
    chk("stall_queued", qA.size(), 4);
    s0 = wrCyc.size();
    busA.im_stall = 1'b0;
    send(4'd2, 5'd10, 5'd11, 5'd12, 26'd0, 1'b0, model(4'd2, 5'd10, 5'd11, 5'd12, 26'd0), 1'b1);
    send(4'd9, 5'd3, 5'd7, 5'd0, 26'h8001, 1'b1, model(4'd9, 5'd3, 5'd7, 5'd0, 26'h8001), 1'b1);
    idleReq();
    waitDone();
    chk("fill_writes", wrCntA - w0, 6);
    for (int i = 0; i < 3; i++) chk("consecutive", wrCyc[s0+i+1] - wrCyc[s0+i], 1);

    // illegal op in the middle
    doStart();
    w0 = wrCntA;
    send(4'd7, 5'd1, 5'd2, 5'd0, 26'h0005, 1'b0, 32'h20220005, 1'b1);
    send(4'd14, 5'd1, 5'd2, 5'd3, 26'h1234, 1'b0, 32'h00000000, !TRAP);
    send(4'd8, 5'd1, 5'd2, 5'd0, 26'hFFFE, 1'b1, 32'h1022FFFE, 1'b1);
    idleReq();
    waitDone();
    chk("illegal_writes", wrCntA - w0, TRAP ? 2 : 3);
    chk("illegal_err", busA.err, TRAP ? 1 : 0);

    // address wrap on the 2-bit instance
    doStart();
    chk("start_clears_errB", busB.err, 0);
    for (int i = 0; i < 5; i++)
      send(4'd12, 5'd31, 5'd7, 5'd9, 26'h155, (i == 4), 32'h03E00008, 1'b1);
    idleReq();
    waitDone();
    chk("wrap_errB", busB.err, 1);
    chk("wrap_errA", busA.err, 0);

    // reset while draining with three words queued
    doStart();
    busA.im_stall = 1'b1;
    send(4'd3, 5'd1, 5'd1, 5'd0, 26'h1, 1'b0, 32'h34210001, 1'b1);
    send(4'd3, 5'd1, 5'd1, 5'd0, 26'h2, 1'b0, 32'h34210002, 1'b1);
    send(4'd3, 5'd1, 5'd1, 5'd0, 26'h3, 1'b1, 32'h34210003, 1'b1);
    idleReq();
    chk("drain_busy", busA.busy, 1);
    chk("drain_ready", busA.req_ready, 0);
    reset = 1'b1;
    qA.delete(); qB.delete();
    tick();
    chkResetVals("midreset");
    reset = 1'b0;
    busA.im_stall = 1'b0;
    w0 = wrCntA;
    repeat (10) tick();
    chk("no_we_after_reset", wrCntA - w0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Instruction encoder and loader for the pipelined MIPS core: the inverse of the ID-stage instruction decoder. It accepts compact instruction descriptors (operation code, register fields, immediate or target) through a valid/ready handshake and encodes each one into a 32-bit MIPS word. Encoded words are buffered in a small FIFO and streamed into consecutive instruction-memory words. It is used to load test programs into IM before the core is released from reset.

## Interface
- DEPTH, 4, FIFO entries (power of two, ≥2)
- ADDR_W, 10, IM word-address width
- BASE_ADDR, 0, first IM word address written after `start`

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- start  in  1  single-cycle pulse; begins a load session from IDLE or DONE
- req_valid  in  1  descriptor valid
- req_ready  out  1  descriptor accepted when valid&ready at a rising edge
- req_op  in  4  0 ADDU, 1 SUBU, 2 ADD, 3 ORI, 4 LUI, 5 LW, 6 SW, 7 ADDI, 8 BEQ, 9 BGTZ, 10 J, 11 JAL, 12 JR, 13–15 illegal
- req_rs, req_rt, req_rd  in  5 each  register fields
- req_imm  in  26  imm16 = [15:0] for I-type; full 26 bits = jump target
- req_last  in  1  marks the final descriptor of the session
- im_stall  in  1  IM write port busy; blocks FIFO pop
- im_we  out  1  IM write strobe, one cycle per word
- im_addr  out  ADDR_W  IM word address
- im_wdata  out  32  encoded instruction
- busy  out  1  high in RUN and DRAIN
- done  out  1  high in DONE
- err  out  1  sticky: illegal op or address wrap

## Operation
- Encodings (shamt always 0; unused fields forced to 0):
  - R-type op 0x00, rs/rt/rd: ADDU func 0x21, SUBU 0x23, ADD 0x20. JR: rs only, func 0x08.
  - I-type rs/rt/imm16: ORI 0x0D, LW 0x23, SW 0x2B, ADDI 0x08, BEQ 0x04. LUI 0x0F with rs=0. BGTZ 0x07 with rt=0.
  - J-type: J 0x02, JAL 0x03, target = req_imm[25:0].
- FSM states IDLE, RUN, DRAIN, DONE:
  - IDLE/DONE → RUN on `start`; address counter ← BASE_ADDR; err cleared.
  - RUN: req_ready = !fifo_full. Accepting a descriptor with req_last=1 → DRAIN.
  - DRAIN: req_ready=0. When the FIFO is empty and no write is pending → DONE.
  - `start` is ignored in RUN and DRAIN.
- Each accepted descriptor is encoded combinationally and pushed into the FIFO at the accepting edge.
- Pop occurs when the FIFO is non-empty and im_stall=0. The output registers load {im_we=1, im_addr=counter, im_wdata=word}, and the counter increments.
- Address counter wraps modulo 2^ADDR_W. The wrap from all-ones to 0 sets err.
- No push-to-pop bypass. Push and pop in the same cycle are allowed when the FIFO is not full.

## Timing
- Reset values: req_ready 0, im_we 0, im_addr BASE_ADDR, im_wdata 0, busy 0, done 0, err 0. FIFO empty, state IDLE.
- Latency: a descriptor accepted at edge k into an empty FIFO with im_stall=0 produces im_we=1 in the cycle after edge k+1.
- im_we is high for exactly one cycle per popped word. im_addr and im_wdata hold their last values while im_we=0.
- done asserts the cycle after the last write cycle ends.
- Reset mid-session (any state) discards FIFO contents; no further im_we follows.

## Configuration
- INSTR_ENC_ILLEGAL_TRAP_EN defined:
  - Illegal req_op (13–15) is accepted, not pushed, and sets err.
  - req_last on an illegal op still moves the FSM to DRAIN.
- Not defined:
  - An illegal op is encoded as 32'h00000000 (NOP) and written normally.
  - err reflects address wrap only.

## Test plan
- reset, start, ADDU rs=1 rt=2 rd=3 last=1 → single im_we at addr 0, wdata 32'h00221821, then done=1, busy=0.
- ORI rs=0 rt=8 imm=0x1234; LUI rs=5 rt=9 imm=0xFFFF; JAL imm=0xC00 last → addrs 0,1,2 with 32'h34081234, 32'h3C09FFFF, 32'h0C000C00.
- DEPTH=4, im_stall=1, six back-to-back valid descriptors → exactly 4 accepted, req_ready=0, no im_we. Release stall → 4 writes on consecutive cycles, remaining 2 accepted.
- With INSTR_ENC_ILLEGAL_TRAP_EN: ADDI, op 14, BEQ last → 2 writes (addrs 0,1: ADDI, BEQ words), err=1. Without the macro: 3 writes, addr 1 = 32'h0, err=0.
- ADDR_W=2, five JR rs=31 → im_addr 0,1,2,3,0, each wdata 32'h03E00008, err=1 after the fifth write.
- Assert reset during DRAIN with 3 words queued → next cycle all outputs at reset values, zero further im_we.
